// File: rtl/dphy_tx_pkg.sv
// Shared definitions for the D-PHY transmit lanes.
// Contents:
//   dphy_clk_tx_state_t : clock-lane TX state encoding
//   DEF_T_*             : default lane timings in bit-clock cycles. These are
//                         shared with the data-lane transmitter.
//   max_u               : helper for sizing timers from timing parameters
package dphy_tx_pkg;

    typedef enum logic [3:0] {
        ST_STOP,
        ST_HS_RQST,
        ST_BRIDGE,
        ST_HS_ZERO,
        ST_HS_PRE,
        ST_HS_RUN,
        ST_HS_POST,
        ST_HS_TRAIL,
        ST_HS_EXIT
    } dphy_clk_tx_state_t;

    localparam int unsigned DEF_T_LPX         = 4;
    localparam int unsigned DEF_T_CLK_PREPARE = 3;
    localparam int unsigned DEF_T_CLK_ZERO    = 20;
    localparam int unsigned DEF_T_CLK_PRE     = 8;
    localparam int unsigned DEF_T_CLK_POST    = 10;
    localparam int unsigned DEF_T_CLK_TRAIL   = 6;
    localparam int unsigned DEF_T_HS_EXIT     = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dphy_tx_timer.sv
// Loadable down-counter used to time the D-PHY TX lane states.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset; clears the count to 0
//   load_i  : load value_i on this edge
//   value_i : count to load. A load of N gives done_o after N further edges.
//   done_o  : count has reached 0. The counter holds at 0 until reloaded.
module dphy_tx_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else if (load_i) begin
            count_reg <= value_i;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done_o = (count_reg == '0);

endmodule

// File: rtl/dphy_clk_lane_tx.sv
// MIPI D-PHY clock-lane transmit controller.
// The entry sequence is LP-11 -> LP-01 -> LP-00 -> HS-0 -> toggling.
// The exit sequence is toggling -> HS-0 trail -> LP-11.
// Ports:
//   clk_i        : bit-rate clock. The lane HS clock is clk_i/2.
//   rst_i        : synchronous active-high reset
//   hs_req_i     : level request for the continuous HS clock
//   hs_ready_o   : HS clock valid; data lanes may transmit
//   stop_state_o : lane idle in LP-11 and able to accept a request
//   lp_p_o/lp_n_o: LP driver levels. They are driven 0/0 while hs_en_o = 1.
//   hs_en_o      : HS driver enable
//   hs_clk_o     : serial HS bit for the clock lane
// All outputs are registered. They are decoded from the state being entered,
// so each output matches the state during the same cycle.
module dphy_clk_lane_tx
    import dphy_tx_pkg::*;
#(
    parameter int unsigned T_LPX         = DEF_T_LPX,
    parameter int unsigned T_CLK_PREPARE = DEF_T_CLK_PREPARE,
    parameter int unsigned T_CLK_ZERO    = DEF_T_CLK_ZERO,
    parameter int unsigned T_CLK_PRE     = DEF_T_CLK_PRE,
    parameter int unsigned T_CLK_POST    = DEF_T_CLK_POST,
    parameter int unsigned T_CLK_TRAIL   = DEF_T_CLK_TRAIL,
    parameter int unsigned T_HS_EXIT     = DEF_T_HS_EXIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic hs_req_i,
    output logic hs_ready_o,
    output logic stop_state_o,
    output logic lp_p_o,
    output logic lp_n_o,
    output logic hs_en_o,
    output logic hs_clk_o
);

    localparam int unsigned T_MAX = max_u(max_u(max_u(T_LPX, T_CLK_PREPARE),
                                                max_u(T_CLK_ZERO, T_CLK_PRE)),
                                          max_u(max_u(T_CLK_POST, T_CLK_TRAIL),
                                                T_HS_EXIT));
    localparam int unsigned TW = $clog2(T_MAX + 1);

    dphy_clk_tx_state_t state_reg, state_next;

    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          timer_done;

    logic lp_p_reg, lp_n_reg, hs_en_reg, hs_clk_reg, ready_reg, stop_reg;
    logic lp_p_next, lp_n_next, hs_en_next, hs_clk_next, ready_next, stop_next;

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_STOP:     if (hs_req_i)   state_next = ST_HS_RQST;
            ST_HS_RQST:  if (timer_done) state_next = ST_BRIDGE;
            ST_BRIDGE:   if (timer_done) state_next = ST_HS_ZERO;
            ST_HS_ZERO:  if (timer_done) state_next = ST_HS_PRE;
            ST_HS_PRE:   if (timer_done) state_next = ST_HS_RUN;
            ST_HS_RUN:   if (!hs_req_i)  state_next = ST_HS_POST;
            // The timer holds at 0, so a cycle whose bit is 0 simply
            // extends POST by one. The lane then always leaves on a 1.
            ST_HS_POST:  if (timer_done && hs_clk_reg) state_next = ST_HS_TRAIL;
            ST_HS_TRAIL: if (timer_done) state_next = ST_HS_EXIT;
            ST_HS_EXIT:  if (timer_done) state_next = ST_STOP;
            default:     state_next = ST_STOP;
        endcase
    end

    // Reload the timer on every state change with (duration - 1) for the state
    // being entered. done is then seen in the last cycle of that state.
    always_comb begin
        timer_load  = (state_next != state_reg);
        timer_value = '0;
        case (state_next)
            ST_HS_RQST:  timer_value = TW'(T_LPX - 1);
            ST_BRIDGE:   timer_value = TW'(T_CLK_PREPARE - 1);
            ST_HS_ZERO:  timer_value = TW'(T_CLK_ZERO - 1);
            ST_HS_PRE:   timer_value = TW'(T_CLK_PRE - 1);
            ST_HS_POST:  timer_value = TW'(T_CLK_POST - 1);
            ST_HS_TRAIL: timer_value = TW'(T_CLK_TRAIL - 1);
            ST_HS_EXIT:  timer_value = TW'(T_HS_EXIT - 1);
            default:     timer_value = '0;
        endcase
    end

    // Output decode for the state being entered
    always_comb begin
        lp_p_next   = 1'b0;
        lp_n_next   = 1'b0;
        hs_en_next  = 1'b0;
        hs_clk_next = 1'b0;
        ready_next  = 1'b0;
        stop_next   = 1'b0;
        case (state_next)
            ST_STOP: begin
                lp_p_next = 1'b1;
                lp_n_next = 1'b1;
                stop_next = 1'b1;
            end
            ST_HS_RQST: lp_n_next = 1'b1;
            ST_BRIDGE:  ;
            ST_HS_ZERO: hs_en_next = 1'b1;
            // hs_clk_reg is 0 throughout HS_ZERO, so the first PRE bit is 1.
            ST_HS_PRE, ST_HS_POST: begin
                hs_en_next  = 1'b1;
                hs_clk_next = ~hs_clk_reg;
            end
            ST_HS_RUN: begin
                hs_en_next  = 1'b1;
                hs_clk_next = ~hs_clk_reg;
                ready_next  = 1'b1;
            end
            ST_HS_TRAIL: hs_en_next = 1'b1;
            ST_HS_EXIT: begin
                lp_p_next = 1'b1;
                lp_n_next = 1'b1;
            end
            default: begin
                lp_p_next = 1'b1;
                lp_n_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_STOP;
            lp_p_reg   <= 1'b1;
            lp_n_reg   <= 1'b1;
            hs_en_reg  <= 1'b0;
            hs_clk_reg <= 1'b0;
            ready_reg  <= 1'b0;
            stop_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            lp_p_reg   <= lp_p_next;
            lp_n_reg   <= lp_n_next;
            hs_en_reg  <= hs_en_next;
            hs_clk_reg <= hs_clk_next;
            ready_reg  <= ready_next;
            stop_reg   <= stop_next;
        end
    end

    dphy_tx_timer #(.WIDTH(TW)) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (timer_load),
        .value_i (timer_value),
        .done_o  (timer_done)
    );

    assign lp_p_o       = lp_p_reg;
    assign lp_n_o       = lp_n_reg;
    assign hs_en_o      = hs_en_reg;
    assign hs_clk_o     = hs_clk_reg;
    assign hs_ready_o   = ready_reg;
    assign stop_state_o = stop_reg;

endmodule

// File: tb/tb_dphy_clk_lane_tx.sv
// Self-checking bench for dphy_clk_lane_tx with default timings.
// The stimulus is a table of segments. Each segment holds rst/hs_req constant
// for n cycles and gives the expected output levels for those cycles. While a
// segment is marked toggling, hs_clk is expected to alternate 1,0,1,...
// continuously across segments. The pattern starts again from 1 after any
// non-toggling segment.
module tb_dphy_clk_lane_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hs_req = 1'b0;
    logic hs_ready, stop_state, lp_p, lp_n, hs_en, hs_clk;

    always #5 clk = ~clk;

    dphy_clk_lane_tx dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .hs_req_i     (hs_req),
        .hs_ready_o   (hs_ready),
        .stop_state_o (stop_state),
        .lp_p_o       (lp_p),
        .lp_n_o       (lp_n),
        .hs_en_o      (hs_en),
        .hs_clk_o     (hs_clk)
    );

    typedef struct {
        string name;
        bit    rst;
        bit    req;
        int    n;
        bit    lp_p;
        bit    lp_n;
        bit    en;
        bit    tog;
        bit    rdy;
        bit    stop;
    } seg_t;

    seg_t segs[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    function automatic seg_t mk(string name, bit r, bit q, int n,
                                bit p, bit nn, bit en, bit tog, bit rdy, bit stop);
        seg_t s;
        s.name = name; s.rst = r; s.req = q; s.n = n;
        s.lp_p = p; s.lp_n = nn; s.en = en; s.tog = tog; s.rdy = rdy; s.stop = stop;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    initial begin
        bit       exp_bit;
        bit [5:0] exp_v, act_v;
        int       cnt;

        // name        rst req  n  lp_p lp_n en tog rdy stop
        // Reset, then a normal entry with a 5-cycle HS_RUN. POST is 10 cycles
        // because its last bit is 1.
        segs.push_back(mk("reset",   1, 0,  2, 1, 1, 0, 0, 0, 1));
        segs.push_back(mk("idle",    0, 0,  2, 1, 1, 0, 0, 0, 1));
        segs.push_back(mk("rqst",    0, 1,  4, 0, 1, 0, 0, 0, 0));
        segs.push_back(mk("bridge",  0, 1,  3, 0, 0, 0, 0, 0, 0));
        segs.push_back(mk("zero",    0, 1, 20, 0, 0, 1, 0, 0, 0));
        segs.push_back(mk("pre",     0, 1,  8, 0, 0, 1, 1, 0, 0));
        segs.push_back(mk("run",     0, 1,  5, 0, 0, 1, 1, 1, 0));
        segs.push_back(mk("post",    0, 0, 10, 0, 0, 1, 1, 0, 0));
        segs.push_back(mk("trail",   0, 0,  6, 0, 0, 1, 0, 0, 0));
        segs.push_back(mk("exit",    0, 0,  8, 1, 1, 0, 0, 0, 0));
        segs.push_back(mk("stop",    0, 0,  2, 1, 1, 0, 0, 0, 1));
        // A one-cycle request pulse still runs the full entry, then HS_RUN for
        // exactly one cycle.
        segs.push_back(mk("ed_rqst1", 0, 1,  1, 0, 1, 0, 0, 0, 0));
        segs.push_back(mk("ed_rqst",  0, 0,  3, 0, 1, 0, 0, 0, 0));
        segs.push_back(mk("ed_bridge",0, 0,  3, 0, 0, 0, 0, 0, 0));
        segs.push_back(mk("ed_zero",  0, 0, 20, 0, 0, 1, 0, 0, 0));
        segs.push_back(mk("ed_pre",   0, 0,  8, 0, 0, 1, 1, 0, 0));
        segs.push_back(mk("ed_run",   0, 0,  1, 0, 0, 1, 1, 1, 0));
        segs.push_back(mk("ed_post",  0, 0, 10, 0, 0, 1, 1, 0, 0));
        segs.push_back(mk("ed_trail", 0, 0,  6, 0, 0, 1, 0, 0, 0));
        segs.push_back(mk("ed_exit",  0, 0,  8, 1, 1, 0, 0, 0, 0));
        segs.push_back(mk("ed_stop",  0, 0,  1, 1, 1, 0, 0, 0, 1));
        // HS_RUN lasts 2 cycles, so the 10th POST bit would be 0 and POST
        // stretches to 11 cycles. The request is re-raised and held through
        // POST/TRAIL/EXIT: one STOP cycle must appear before HS_RQST.
        segs.push_back(mk("hr_rqst",  0, 1,  4, 0, 1, 0, 0, 0, 0));
        segs.push_back(mk("hr_bridge",0, 1,  3, 0, 0, 0, 0, 0, 0));
        segs.push_back(mk("hr_zero",  0, 1, 20, 0, 0, 1, 0, 0, 0));
        segs.push_back(mk("hr_pre",   0, 1,  8, 0, 0, 1, 1, 0, 0));
        segs.push_back(mk("hr_run",   0, 1,  2, 0, 0, 1, 1, 1, 0));
        segs.push_back(mk("hr_post_a",0, 0,  1, 0, 0, 1, 1, 0, 0));
        segs.push_back(mk("hr_post_b",0, 1, 10, 0, 0, 1, 1, 0, 0));
        segs.push_back(mk("hr_trail", 0, 1,  6, 0, 0, 1, 0, 0, 0));
        segs.push_back(mk("hr_exit",  0, 1,  8, 1, 1, 0, 0, 0, 0));
        segs.push_back(mk("hr_stop",  0, 1,  1, 1, 1, 0, 0, 0, 1));
        segs.push_back(mk("hr_rqst2", 0, 1,  4, 0, 1, 0, 0, 0, 0));
        segs.push_back(mk("hr_bridge2",0,1,  3, 0, 0, 0, 0, 0, 0));
        segs.push_back(mk("hr_zero2", 0, 1,  5, 0, 0, 1, 0, 0, 0));
        // Reset during HS_ZERO: reset values on the next edge, no trail.
        segs.push_back(mk("mid_rst",  1, 1,  1, 1, 1, 0, 0, 0, 1));
        segs.push_back(mk("post_rst", 0, 0,  2, 1, 1, 0, 0, 0, 1));

        exp_bit = 1'b1;
        foreach (segs[si]) begin
            for (int k = 0; k < segs[si].n; k++) begin
                rst    = segs[si].rst;
                hs_req = segs[si].req;
                step();
                exp_v = {segs[si].lp_p, segs[si].lp_n, segs[si].en,
                         segs[si].tog ? exp_bit : 1'b0, segs[si].rdy, segs[si].stop};
                act_v = {lp_p, lp_n, hs_en, hs_clk, hs_ready, stop_state};
                checks++;
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL %s[%0d] cycle %0d {lp_p,lp_n,en,clk,rdy,stop} got %b want %b",
                             segs[si].name, k, cycle, act_v, exp_v);
                end
                if (segs[si].tog) exp_bit = ~exp_bit;
                else              exp_bit = 1'b1;
            end
            $display("segment %-10s cycles=%0d done", segs[si].name, segs[si].n);
        end

        // Hand-written: measure request-to-ready latency (expected 36),
        // ready falling one cycle after the drop, and the return to STOP
        // 24 cycles later (POST 10 + TRAIL 6 + EXIT 8).
        hs_req = 1'b1;
        step();
        cnt = 1;
        while (!hs_ready && cnt < 100) begin
            step();
            cnt++;
        end
        checks++;
        if (cnt != 36) begin
            failures++;
            $display("FAIL ready_latency got %0d want 36", cnt);
        end
        $display("latency: hs_ready after %0d cycles", cnt);

        hs_req = 1'b0;
        step();
        checks++;
        if (hs_ready !== 1'b0 || hs_en !== 1'b1) begin
            failures++;
            $display("FAIL ready_fall got rdy=%b en=%b want rdy=0 en=1", hs_ready, hs_en);
        end
        $display("drop: rdy=%b en=%b", hs_ready, hs_en);

        cnt = 0;
        while (!stop_state && cnt < 100) begin
            step();
            cnt++;
        end
        checks++;
        if (cnt != 24) begin
            failures++;
            $display("FAIL exit_to_stop got %0d want 24", cnt);
        end
        $display("exit: stop_state after %0d cycles", cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
